// File: rtl/pong_ctrl.sv
// pong_ctrl: 1D pong game sequencer for an 8-LED strip.
// Generates the ball-step tick, moves the ball, runs the
// serve / rally / point / game-over flow and keeps both scores.
module pong_ctrl #(
  parameter int WIN_SCORE = 5
) (
  input  logic        _i_clk,
  input  logic        _i_rst,
  input  logic [31:0] _i_tick_length,
  input  logic        _i_btn_left,
  input  logic        _i_btn_right,
  output logic [7:0]  leds,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic        game_over,
  output logic        tick
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SERVE  = 3'd1;
  localparam logic [2:0] MOVE_R = 3'd2;
  localparam logic [2:0] MOVE_L = 3'd3;
  localparam logic [2:0] POINT  = 3'd4;
  localparam logic [2:0] OVER   = 3'd5;

  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  logic [2:0]  state_q, state_d;
  logic [2:0]  pos_q, pos_d;
  logic        server_q, server_d;
  logic [3:0]  scoreLeft_q, scoreLeft_d;
  logic [3:0]  scoreRight_q, scoreRight_d;
  logic [31:0] cnt_q, cnt_d;
  logic        btnLeft_q, btnRight_q;

  logic [31:0] lenEff;
  logic        pressLeft, pressRight;
  logic        enteringMove;

  // Rising-edge press detection and tick decode; a zero length behaves as one.
  always_comb begin
    lenEff     = (_i_tick_length == 32'd0) ? 32'd1 : _i_tick_length;
    tick       = (cnt_q >= (lenEff - 32'd1));
    pressLeft  = _i_btn_left & ~btnLeft_q;
    pressRight = _i_btn_right & ~btnRight_q;
  end

  // Game state machine: serve, rally with hits and misses, point pause, game over.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    server_d     = server_q;
    scoreLeft_d  = scoreLeft_q;
    scoreRight_d = scoreRight_q;
    case (state_q)
      IDLE: begin
        if (pressLeft || pressRight) begin
          state_d  = SERVE;
          server_d = 1'b0;
          pos_d    = 3'd0;
        end
      end
      SERVE: begin
        if (!server_q && pressLeft) begin
          state_d = MOVE_R;
        end else if (server_q && pressRight) begin
          state_d = MOVE_L;
        end
      end
      MOVE_R: begin
        if ((pos_q == 3'd7) && pressRight) begin
          state_d = MOVE_L;
        end else if (tick) begin
          if (pos_q != 3'd7) begin
            pos_d = pos_q + 3'd1;
          end else begin
            scoreLeft_d = (scoreLeft_q == 4'd15) ? 4'd15 : scoreLeft_q + 4'd1;
            server_d    = 1'b1;
            state_d     = POINT;
          end
        end
      end
      MOVE_L: begin
        if ((pos_q == 3'd0) && pressLeft) begin
          state_d = MOVE_R;
        end else if (tick) begin
          if (pos_q != 3'd0) begin
            pos_d = pos_q - 3'd1;
          end else begin
            scoreRight_d = (scoreRight_q == 4'd15) ? 4'd15 : scoreRight_q + 4'd1;
            server_d     = 1'b0;
            state_d      = POINT;
          end
        end
      end
      POINT: begin
        // server_q already holds the player who lost the point.
        if (tick) begin
          if ((server_q ? scoreLeft_q : scoreRight_q) == WIN) begin
            state_d = OVER;
          end else begin
            state_d = SERVE;
            pos_d   = server_q ? 3'd7 : 3'd0;
          end
        end
      end
      OVER: begin
        if (pressLeft || pressRight) begin
          state_d      = IDLE;
          scoreLeft_d  = 4'd0;
          scoreRight_d = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Tick counter restarts on every serve or hit so the first step is a full period.
  always_comb begin
    enteringMove = ((state_d == MOVE_R) || (state_d == MOVE_L)) && (state_d != state_q);
    if (enteringMove || tick) begin
      cnt_d = 32'd0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      state_q      <= IDLE;
      pos_q        <= 3'd0;
      server_q     <= 1'b0;
      scoreLeft_q  <= 4'd0;
      scoreRight_q <= 4'd0;
      cnt_q        <= 32'd0;
      btnLeft_q    <= 1'b0;
      btnRight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      server_q     <= server_d;
      scoreLeft_q  <= scoreLeft_d;
      scoreRight_q <= scoreRight_d;
      cnt_q        <= cnt_d;
      btnLeft_q    <= _i_btn_left;
      btnRight_q   <= _i_btn_right;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    score_left  = scoreLeft_q;
    score_right = scoreRight_q;
    game_over   = (state_q == OVER);
    case (state_q)
      SERVE, MOVE_R, MOVE_L: leds = 8'd1 << pos_q;
      POINT:                 leds = 8'hFF;
      OVER:                  leds = server_q ? 8'hF0 : 8'h0F;
      default:               leds = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_pong_ctrl.sv
// tb_pong_ctrl: randomized self-checking bench for pong_ctrl against a
// direction-based behavioural model of the game.
module tb_pong_ctrl;

  localparam int WIN = 5;

  logic        clk;
  logic        rst;
  logic [31:0] len;
  logic        bl, br;
  logic [7:0]  leds;
  logic [3:0]  scoreLeft, scoreRight;
  logic        gameOver, tickOut;

  int checks   = 0;
  int failures = 0;
  bit sawOver  = 0;
  bit sawHit   = 0;

  pong_ctrl #(.WIN_SCORE(WIN)) dut (
    ._i_clk         (clk),
    ._i_rst         (rst),
    ._i_tick_length (len),
    ._i_btn_left    (bl),
    ._i_btn_right   (br),
    .leds           (leds),
    .score_left     (scoreLeft),
    .score_right    (scoreRight),
    .game_over      (gameOver),
    .tick           (tickOut)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {PH_IDLE, PH_SERVE, PH_RALLY, PH_POINT, PH_OVER} phase_t;

  // Behavioural model: ball position plus direction, who scored, plain counters.
  phase_t mPhase;
  int     mBall;
  int     mDir;
  int     mServer;
  int     mScorer;
  int     mScore[2];
  longint mCnt;
  bit     mPrevL, mPrevR;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      if (failures <= 40)
        $display("[TB] FAIL %s t=%0t observed=0x%0h expected=0x%0h", tag, $time, observed, expected);
    end
  endtask

  function automatic bit modelTick();
    longint period;
    period = (len == 32'd0) ? 1 : longint'(len);
    return mCnt >= period - 1;
  endfunction

  function automatic logic [7:0] modelLeds();
    case (mPhase)
      PH_SERVE, PH_RALLY: return 8'(1 << mBall);
      PH_POINT:           return 8'hFF;
      PH_OVER:            return (mScore[0] == WIN) ? 8'hF0 : 8'h0F;
      default:            return 8'h00;
    endcase
  endfunction

  task automatic modelReset();
    mPhase   = PH_IDLE;
    mBall    = 0;
    mDir     = 1;
    mServer  = 0;
    mScorer  = 0;
    mScore[0] = 0;
    mScore[1] = 0;
    mCnt     = 0;
    mPrevL   = 0;
    mPrevR   = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelAdvance();
    bit pL, pR, t, rp;
    int endPos;
    if (rst) begin
      modelReset();
      return;
    end
    pL = bl && !mPrevL;
    pR = br && !mPrevR;
    mPrevL = bl;
    mPrevR = br;
    t = modelTick();
    mCnt = t ? 0 : mCnt + 1;
    case (mPhase)
      PH_IDLE: begin
        if (pL || pR) begin
          mPhase  = PH_SERVE;
          mServer = 0;
          mBall   = 0;
        end
      end
      PH_SERVE: begin
        if ((mServer == 0 && pL) || (mServer == 1 && pR)) begin
          mPhase = PH_RALLY;
          mDir   = (mServer == 0) ? 1 : -1;
          mCnt   = 0;
        end
      end
      PH_RALLY: begin
        endPos = (mDir > 0) ? 7 : 0;
        rp     = (mDir > 0) ? pR : pL;
        if (mBall == endPos && rp) begin
          mDir   = -mDir;
          mCnt   = 0;
          sawHit = 1;
        end else if (t) begin
          if (mBall != endPos) begin
            mBall = mBall + mDir;
          end else begin
            mScorer = (mDir > 0) ? 0 : 1;
            if (mScore[mScorer] < 15) mScore[mScorer]++;
            mPhase = PH_POINT;
          end
        end
      end
      PH_POINT: begin
        if (t) begin
          if (mScore[mScorer] == WIN) begin
            mPhase = PH_OVER;
          end else begin
            mServer = 1 - mScorer;
            mBall   = (mServer == 1) ? 7 : 0;
            mPhase  = PH_SERVE;
          end
        end
      end
      default: begin
        if (pL || pR) begin
          mPhase    = PH_IDLE;
          mScore[0] = 0;
          mScore[1] = 0;
        end
      end
    endcase
  endtask

  // Drive one cycle of inputs at the falling edge, check outputs, then step the model.
  task automatic applyStimulus(input logic r, input logic [31:0] l, input logic b_l, input logic b_r);
    @(negedge clk);
    rst = r;
    len = l;
    bl  = b_l;
    br  = b_r;
    #1;
    checkOutput("leds",       32'(leds),       32'(modelLeds()));
    checkOutput("scoreLeft",  32'(scoreLeft),  32'(mScore[0]));
    checkOutput("scoreRight", 32'(scoreRight), 32'(mScore[1]));
    checkOutput("gameOver",   32'(gameOver),   32'(mPhase == PH_OVER));
    checkOutput("tick",       32'(tickOut),    32'(modelTick()));
    if (gameOver === 1'b1) sawOver = 1;
    modelAdvance();
  endtask

  // Player behaviour: servers serve, receivers usually hit at their end, plus noise.
  task automatic chooseButtons(input int hitPct, output logic b_l, output logic b_r);
    b_l = 1'b0;
    b_r = 1'b0;
    case (mPhase)
      PH_IDLE, PH_OVER: begin
        if ($urandom % 6 == 0) begin
          if ($urandom % 2 == 0) b_l = 1'b1; else b_r = 1'b1;
        end
      end
      PH_SERVE: begin
        if ($urandom % 4 == 0) begin
          if (mServer == 0) b_l = 1'b1; else b_r = 1'b1;
        end
      end
      PH_RALLY: begin
        if (mDir > 0 && mBall == 7 && int'($urandom % 100) < hitPct) b_r = 1'b1;
        if (mDir < 0 && mBall == 0 && int'($urandom % 100) < hitPct) b_l = 1'b1;
      end
      default: ;
    endcase
    if ($urandom % 20 == 0) b_l = 1'b1;
    if ($urandom % 20 == 0) b_r = 1'b1;
  endtask

  // Main sequence: reset, long play at length 3, length 0, 100 to 2 change, random mix.
  initial begin
    logic        nl, nr;
    logic [31:0] curLen;
    rst = 1'b1;
    len = 32'd3;
    bl  = 1'b0;
    br  = 1'b0;
    modelReset();
    @(posedge clk);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'd3, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      chooseButtons(45, nl, nr);
      applyStimulus(1'b0, 32'd3, nl, nr);
    end

    for (int i = 0; i < 500; i++) begin
      chooseButtons(60, nl, nr);
      applyStimulus(1'b0, 32'd0, nl, nr);
    end

    for (int i = 0; i < 150; i++) begin
      chooseButtons(30, nl, nr);
      applyStimulus(1'b0, 32'd100, nl, nr);
    end
    for (int i = 0; i < 400; i++) begin
      chooseButtons(50, nl, nr);
      applyStimulus(1'b0, 32'd2, nl, nr);
    end

    curLen = 32'd4;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom % 300 == 0) curLen = 32'($urandom_range(0, 6));
      chooseButtons(50, nl, nr);
      applyStimulus(($urandom % 400 == 0) ? 1'b1 : 1'b0, curLen, nl, nr);
    end

    checkOutput("reachedOver", 32'(sawOver), 32'd1);
    checkOutput("reachedHit",  32'(sawHit),  32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
